// File: rtl/instr_encoder_loader_if.sv
// Field-bundle input stream and instruction-memory write port of the loader.
// slave: the loader itself; master: the field source / memory side.
interface instr_encoder_loader_if #(
    parameter int unsigned ADDR_W = 32
);
    logic              in_valid;
    logic              in_ready;
    logic              in_last;
    logic [3:0]        in_cond;
    logic [1:0]        in_op;
    logic [5:0]        in_funct;
    logic [3:0]        in_rn;
    logic [3:0]        in_rd;
    logic [11:0]       in_src2;
    logic [23:0]       in_imm24;
    logic              im_we;
    logic              im_wready;
    logic [ADDR_W-1:0] im_addr;
    logic [31:0]       im_wdata;

    modport master (
        output in_valid, in_last, in_cond, in_op, in_funct, in_rn, in_rd, in_src2, in_imm24,
        output im_wready,
        input  in_ready, im_we, im_addr, im_wdata
    );

    modport slave (
        input  in_valid, in_last, in_cond, in_op, in_funct, in_rn, in_rd, in_src2, in_imm24,
        input  im_wready,
        output in_ready, im_we, im_addr, im_wdata
    );
endinterface

// File: rtl/instr_encoder_loader.sv
// Packs decoded ARM-subset fields into instruction words and streams them to instruction memory.
// Optional legality checking of bundles is enabled by defining ENC_CHECK_EN.
module instr_encoder_loader #(
    parameter int unsigned       ADDR_W    = 32,
    parameter logic [ADDR_W-1:0] BASE_ADDR = '0,
    parameter int unsigned       MAX_WORDS = 64
) (
    input  logic                               clk,
    input  logic                               rst_n,
    input  logic                               start,
    instr_encoder_loader_if.slave              bus,
    output logic [$clog2(MAX_WORDS+1)-1:0]     word_cnt,
    output logic                               done,
    output logic [1:0]                         err
);
    localparam int unsigned CntW = $clog2(MAX_WORDS + 1);

    typedef enum logic [1:0] {StIdle, StLoad, StWrite, StDone} state_e;

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [31:0]       wdata_q, wdata_d;
    logic [CntW-1:0]   cnt_q, cnt_d;
    logic              last_q, last_d;
    logic [1:0]        err_q, err_d;

    logic [31:0]       enc_word;
    logic              legal;
    logic [CntW-1:0]   cnt_inc;

    // Branches carry imm24; every other op uses the data-processing/memory layout.
    always_comb begin
        if (bus.in_op == 2'b10) begin
            enc_word = {bus.in_cond, 2'b10, bus.in_funct[5:4], bus.in_imm24};
        end else begin
            enc_word = {bus.in_cond, bus.in_op, bus.in_funct, bus.in_rn, bus.in_rd, bus.in_src2};
        end
    end

`ifdef ENC_CHECK_EN
    always_comb begin
        case (bus.in_op)
            2'b00:   legal = bus.in_funct[4:1] inside {4'b0100, 4'b0010, 4'b0000, 4'b1100};
            2'b01:   legal = 1'b1;
            2'b10:   legal = (bus.in_funct[5:4] == 2'b10);
            default: legal = 1'b0;
        endcase
    end
`else
    assign legal = 1'b1;
`endif

    assign cnt_inc = cnt_q + CntW'(1);

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        cnt_d   = cnt_q;
        last_d  = last_q;
        err_d   = err_q;
        case (state_q)
            StIdle, StDone: begin
                if (start) begin
                    state_d = StLoad;
                    addr_d  = BASE_ADDR;
                    cnt_d   = '0;
                    err_d   = '0;
                end
            end
            StLoad: begin
                if (bus.in_valid) begin
                    wdata_d = enc_word;
                    last_d  = bus.in_last;
                    if (legal) begin
                        state_d = StWrite;
                    end else begin
                        err_d[0] = 1'b1;
                        if (bus.in_last) state_d = StDone;
                    end
                end
            end
            StWrite: begin
                if (bus.im_wready) begin
                    addr_d = addr_q + ADDR_W'(4);
                    cnt_d  = cnt_inc;
                    if (last_q) begin
                        state_d = StDone;
                    end else if (cnt_inc == CntW'(MAX_WORDS)) begin
                        state_d  = StDone;
                        err_d[1] = 1'b1;
                    end else begin
                        state_d = StLoad;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= StIdle;
            addr_q  <= BASE_ADDR;
            wdata_q <= '0;
            cnt_q   <= '0;
            last_q  <= 1'b0;
            err_q   <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            cnt_q   <= cnt_d;
            last_q  <= last_d;
            err_q   <= err_d;
        end
    end

    assign bus.in_ready = (state_q == StLoad);
    assign bus.im_we    = (state_q == StWrite);
    assign bus.im_addr  = addr_q;
    assign bus.im_wdata = wdata_q;
    assign word_cnt     = cnt_q;
    assign done         = (state_q == StDone);
    assign err          = err_q;
endmodule
